muldiv_ctrl: RTL and testbench

Iterative multiply controller that computes 32×32→64-bit MULT/MULTU products into HI/LO registers. It performs all partial-product additions on the existing shared 32-bit ALU instead of a dedicated adder. It sits beside the datapath: while it owns the ALU it asserts `alu_own`, and the datapath operand/op mux then routes `alu_a`/`alu_b`/`alu_op` from this block. HI/LO feed the MFHI/MFLO path.

---
 rtl/muldiv_ctrl_pkg.sv | 30 +++
 rtl/alu.sv | 23 ++
 rtl/muldiv_ctrl.sv | 112 +++++++++++
 tb/tb_muldiv_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply controller and the datapath ALU.
package muldiv_ctrl_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_PASSB = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_NEG  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        NEG  = ST_NEG,
        DONE = ST_DONE
    } state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is correct as unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? WIDTH'(~x + WIDTH'(1)) : x;
    endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational 32-bit datapath ALU (zero-latency result).
module alu
    import muldiv_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_OR:    result = a | b;
            ALU_PASSB: result = b;
            ALU_SLT:   result = {31'b0, $signed(a) < $signed(b)};
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative shift-add MULT/MULTU controller that borrows the shared ALU for every
// partial-product addition and leaves the 64-bit product in hi/lo.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] alu_result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_own,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t             state, state_n;
    logic [WIDTH-1:0]   mcand, mcand_n;
    logic [WIDTH-1:0]   hi_n, lo_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               neg, neg_n;
    logic               sgn, sgn_n;
    logic               carry;
    logic [2*WIDTH-1:0] prod;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            sgn   <= 1'b0;
        end else begin
            state <= state_n;
            mcand <= mcand_n;
            hi    <= hi_n;
            lo    <= lo_n;
            cnt   <= cnt_n;
            neg   <= neg_n;
            sgn   <= sgn_n;
        end
    end

    always_comb begin
        state_n = state;
        mcand_n = mcand;
        hi_n    = hi;
        lo_n    = lo;
        cnt_n   = cnt;
        neg_n   = neg;
        sgn_n   = sgn;
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = ALU_ADD;
        alu_own = 1'b0;
        busy    = (state != IDLE);
        done    = 1'b0;
        carry   = 1'b0;
        prod    = {hi, lo};

        case (state)
            IDLE: begin
                if (start) begin
                    mcand_n = is_signed ? abs_val(rs) : rs;
                    lo_n    = is_signed ? abs_val(rt) : rt;
                    hi_n    = '0;
                    neg_n   = is_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                    cnt_n   = '0;
                    sgn_n   = is_signed;
                    state_n = CALC;
                end
            end
            CALC: begin
                alu_own = 1'b1;
                alu_a   = hi;
                alu_b   = lo[0] ? mcand : '0;
                alu_op  = ALU_ADD;
                // ALU is only 32 bits wide; recover the carry-out from the operand/result MSBs.
                carry   = (alu_a[WIDTH-1] & alu_b[WIDTH-1])
                        | ((alu_a[WIDTH-1] | alu_b[WIDTH-1]) & ~alu_result[WIDTH-1]);
                hi_n    = {carry, alu_result[WIDTH-1:1]};
                lo_n    = {alu_result[0], lo[WIDTH-1:1]};
                cnt_n   = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_n = sgn ? NEG : DONE;
                end
            end
            NEG: begin
                if (neg) begin
                    prod = (2*WIDTH)'(~{hi, lo} + (2*WIDTH)'(1));
                end
                hi_n    = prod[2*WIDTH-1:WIDTH];
                lo_n    = prod[WIDTH-1:0];
                state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised and directed bench for muldiv_ctrl wired to the shared ALU.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic [31:0] alu_result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic        alu_own;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_signed  (is_signed),
        .rs         (rs),
        .rt         (rt),
        .alu_result (alu_result),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_own    (alu_own),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    // Issue one operation; optionally pulse a stray start (rs=rt=9) in cycle poke.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, input int poke);
        int own_cnt;
        int busy_cnt;
        int done_cyc;
        int alu_op_bad;
        logic [63:0] exp;
        own_cnt    = 0;
        busy_cnt   = 0;
        done_cyc   = 0;
        alu_op_bad = 0;
        @(negedge clk);
        check("idle_before_start", {63'b0, busy}, 64'd0);
        start     = 1'b1;
        is_signed = s;
        rs        = a;
        rt        = b;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c == poke);
            if (c == poke) begin
                rs        = 32'd9;
                rt        = 32'd9;
                is_signed = 1'b0;
            end
            if (alu_own) own_cnt++;
            if (busy) busy_cnt++;
            if (alu_op != 3'b000) alu_op_bad++;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
        exp = ref_prod(s, a, b);
        check("done_cycle", 64'(done_cyc), s ? 64'd34 : 64'd33);
        check("alu_own_cycles", 64'(own_cnt), 64'd32);
        check("busy_cycles", 64'(busy_cnt), 64'(done_cyc));
        check("alu_op_add", 64'(alu_op_bad), 64'd0);
        check("hi", {32'b0, hi}, {32'b0, exp[63:32]});
        check("lo", {32'b0, lo}, {32'b0, exp[31:0]});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rsg;
        int          dcount;

        #12;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_own", {63'b0, alu_own}, 64'd0);
        check("rst_alu_a", {32'b0, alu_a}, 64'd0);
        check("rst_alu_b", {32'b0, alu_b}, 64'd0);
        check("rst_alu_op", {61'b0, alu_op}, 64'd0);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(1'b0, 32'd3, 32'd5, 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(1'b1, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 0);

        // Stray start while busy must be dropped, not queued.
        run_op(1'b0, 32'd3, 32'd5, 5);
        dcount = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("no_second_done", 64'(dcount), 64'd0);
        check("hold_lo", {32'b0, lo}, 64'd15);
        check("hold_hi", {32'b0, hi}, 64'd0);

        // Back-to-back: next start issued in the cycle after done.
        run_op(1'b1, 32'd100, 32'hFFFF_FF9C, 0);
        run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        rs        = 32'd3;
        rt        = 32'd5;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_own", {63'b0, alu_own}, 64'd0);
        check("abort_hi", {32'b0, hi}, 64'd0);
        check("abort_lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(1'b0, 32'd6, 32'd7, 0);

        for (int i = 0; i < 24; i++) begin
            rsg = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: rb = 32'd0;
                2: ra = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(rsg, ra, rb, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
